// File: rtl/mod_m_counter_prog.sv
// Runtime-programmable modulus-m counter with up/down, clear, load,
// cascade wrap tick and a modulus change that is deferred to a wrap point.
module mod_m_counter_prog #(
  parameter int W         = 8,
  parameter int M_DEFAULT = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  input  logic         up,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] m_in,
  input  logic         m_update,
  output logic [W-1:0] count,
  output logic [W-1:0] m_cur,
  output logic         m_pending,
  output logic         max_tick,
  output logic         min_tick,
  output logic         wrap_tick
);

  localparam logic [W-1:0] M_RST = W'(M_DEFAULT);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] m_pend;
  logic [W-1:0] term;
  logic [W-1:0] m_nxt;
  logic [W-1:0] term_nxt;
  logic [W-1:0] count_d;
  logic         apply;

  // m_cur of 0 wraps to all ones: the full 2^W range
  assign term     = m_cur - ONE;
  assign m_nxt    = m_pending ? m_pend : m_cur;
  assign term_nxt = m_nxt - ONE;

  assign max_tick  = (count == term);
  assign min_tick  = (count == '0);
  assign wrap_tick = en & (up ? max_tick : min_tick);

  always_comb begin
    count_d = count;
    apply   = 1'b0;
    if (clr) begin
      count_d = '0;
      apply   = 1'b1;
    end else if (load) begin
      apply = 1'b1;
      if (m_nxt != '0 && load_val >= m_nxt)
        count_d = term_nxt;
      else
        count_d = load_val;
    end else if (en) begin
      if (up) begin
        if (max_tick) begin
          count_d = '0;
          apply   = 1'b1;
        end else begin
          count_d = count + ONE;
        end
      end else begin
        if (min_tick) begin
          count_d = term_nxt;
          apply   = 1'b1;
        end else begin
          count_d = count - ONE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count     <= '0;
      m_cur     <= M_RST;
      m_pend    <= '0;
      m_pending <= 1'b0;
    end else begin
      count <= count_d;
      if (apply) begin
        m_cur     <= m_nxt;
        m_pending <= 1'b0;
      end
      // a capture on the apply edge stays pending for the next one
      if (m_update) begin
        m_pend    <= m_in;
        m_pending <= 1'b1;
      end
    end
  end

endmodule
